conv_output_serializer: RTL and testbench

Streams the result map of the combinational convolution filter out as one 32-bit Q16.15 word per beat over a valid/ready channel. It captures the filter's full parallel output map in one cycle, then drains it element by element in row-major order, flagging the last element. It sits between the `conv_filter` output bus and downstream consumers such as a pooling stage or a memory writer.

---
 rtl/conv_output_serializer.sv | 113 +++++++++++
 tb/tb_conv_output_serializer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_serializer.sv
// conv_output_serializer
// Captures the full conv_filter output map (N words of Q16.15) in one cycle
// and streams it out one word per beat, row-major, flagging the last word.
//
// Optional feature: define CONV_SER_RELU_EN to clamp negative words to zero
// as they are captured. Without it, words are stored and streamed bit-exact.
//
// Handshake (both channels): a transfer happens on a rising edge where
// valid && ready are both 1. in_ready and all out_* signals are decoded from
// registered state only, so neither in_valid nor out_ready reaches an output.
module conv_output_serializer #(
  parameter int input_size  = 7,
  parameter int filter_size = 5,
  parameter int stride      = 2,
  localparam int out_dim    = (input_size - filter_size) / stride + 1,
  localparam int N          = out_dim * out_dim,
  localparam int IDXW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*32-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [IDXW-1:0]   out_index,
  output logic              out_last
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] cnt;
  logic [31:0]     mem [N];
  logic            capture;
  logic            beat;
  logic            at_last;

  // Word conditioning applied on the way into the capture buffer.
  function automatic logic [31:0] store_word(input logic [31:0] w);
`ifdef CONV_SER_RELU_EN
    return w[31] ? 32'h0000_0000 : w;
`else
    return w;
`endif
  endfunction

  // Handshake qualifiers derived from the registered state.
  assign capture = (state == IDLE) && in_valid;
  assign beat    = (state == STREAM) && out_ready;
  assign at_last = (cnt == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: capture starts a stream, the beat on the last index ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture)          state_nxt = STREAM;
      STREAM:  if (beat && at_last)  state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Element counter: cleared on capture, advanced per beat, never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (capture)           cnt <= '0;
    else if (beat && !at_last)  cnt <= cnt + 1'b1;
  end

  // Capture buffer: in_data is sampled only on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) mem[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < N; k++) mem[k] <= store_word(in_data[32*k +: 32]);
    end
  end

  // Output decode: everything is zero unless a word is being presented.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      STREAM: begin
        out_valid = 1'b1;
        out_data  = mem[cnt];
        out_index = cnt;
        out_last  = at_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_output_serializer.sv
// tb_conv_output_serializer
// Default instance (7/5/2 -> N = 4) driven from a vector table plus
// hand-written sequences; a second instance (5/5 -> N = 1) covers the
// single-element map. Build with CONV_SER_RELU_EN to match a ReLU build.
module tb_conv_output_serializer;

  localparam int N    = 4;
  localparam int IDXW = 2;
  localparam int W    = 39;  // {index[5:0], last, data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (N = 4) ----------------
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [N*32-1:0] in_data   = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_data;
  logic [IDXW-1:0] out_index;
  logic            out_last;

  conv_output_serializer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  // ---------------- DUT (N = 1) ----------------
  logic        s_in_valid  = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_in_data   = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [31:0] s_out_data;
  logic [0:0]  s_out_index;
  logic        s_out_last;

  conv_output_serializer #(.input_size(5), .filter_size(5), .stride(2)) u_one (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_index (s_out_index),
    .out_last  (s_out_last)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]    exp_q[$];
  logic [N*32-1:0] cur_exp = '0;
  int              cap_cnt = 0;
  int              n_vec   = 0;
  int              n_err   = 0;

  typedef struct {
    logic [N*32-1:0] map;
    logic [N*32-1:0] exp_map;
    logic [6:0]      rdy;      // bit i = out_ready in cycle i (repeats)
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef CONV_SER_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [N*32-1:0] model_map(input logic [N*32-1:0] m);
    logic [N*32-1:0] r;
    for (int k = 0; k < N; k++) r[32*k +: 32] = model_word(m[32*k +: 32]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_stall = 1'b0;
  logic [35:0] prev_out   = '0;

  // Sampled on the falling edge: checks handshake state against the model,
  // pops one expected word per beat, and pushes a whole map per capture.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      logic         exp_idle;
      logic [W-1:0] e;
      exp_idle = (exp_q.size() == 0);
      check("in_ready", 64'(in_ready), 64'(exp_idle));
      check("out_valid", 64'(out_valid), 64'(!exp_idle));
      if (!out_valid)
        check("idle_outputs_zero", 64'({out_data, out_index, out_last}), 64'h0);
      if (prev_stall)
        check("stall_stable", 64'({out_valid, out_data, out_index, out_last}), 64'(prev_out));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(out_data), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e[31:0]));
          check("out_index", 64'(out_index), 64'(e[38:33]));
          check("out_last", 64'(out_last), 64'(e[32]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_data, out_index, out_last};
      if (exp_idle && in_valid) begin
        for (int k = 0; k < N; k++)
          exp_q.push_back({6'(k), (k == N - 1), cur_exp[32*k +: 32]});
        cap_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one map, hold in_valid until captured, drain with the ready pattern.
  task automatic run_map(input vec_t v);
    int  c0;
    bit  done;
    c0   = cap_cnt;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = v.map;
    cur_exp  = v.exp_map;
    for (int i = 0; i < 100 && !done; i++) begin
      out_ready = v.rdy[i % 7];
      step();
      if (cap_cnt != c0 && in_valid) begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};  // must be ignored
      end
      if (cap_cnt != c0 && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("run_map_timeout", 64'(cap_cnt - c0), 64'(1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t a, b;
    bit   done;
    int   c0;

    // Table: basic drain, backpressure, ReLU words, two random maps.
    vecs[0].map = {32'h0, 32'h0001_0000, 32'h0, 32'h0000_8000};
    vecs[0].rdy = 7'b1111111;
    vecs[1].map = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    vecs[1].rdy = 7'b1101001;  // 1,0,0,1,0,1,1
    vecs[2].map = {32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_8000, 32'hFFFF_8000};
    vecs[2].rdy = 7'b1111111;
    for (int j = 3; j < 5; j++) begin
      vecs[j].map = {$urandom, $urandom, $urandom, $urandom};
      vecs[j].rdy = 7'($urandom_range(0, 127)) | 7'b0000001;
    end
    for (int j = 0; j < 5; j++) vecs[j].exp_map = model_map(vecs[j].map);
    // Fixed expectations for the ReLU vector, independent of model_map.
`ifdef CONV_SER_RELU_EN
    vecs[2].exp_map = {32'h7FFF_FFFF, 32'h0, 32'h0000_8000, 32'h0};
`else
    vecs[2].exp_map = vecs[2].map;
`endif

    // Reset state, both instances.
    repeat (3) step();
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_outputs", 64'({out_valid, out_data, out_index, out_last}), 64'h0);
    check("rst_one", 64'({s_in_ready, s_out_valid, s_out_data, s_out_index, s_out_last}),
          64'({1'b1, 35'h0}));
    rst_n = 1'b1;
    step();

    for (int j = 0; j < 5; j++) run_map(vecs[j]);

    // Capture lockout: map b held on in_data throughout map a's stream.
    a = vecs[1];
    a.rdy = 7'b0110101;
    b = vecs[3];
    c0 = cap_cnt;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = a.map;
    cur_exp  = a.exp_map;
    for (int i = 0; i < 100 && !done; i++) begin
      out_ready = a.rdy[i % 7];
      step();
      if (cap_cnt == c0 + 1 && in_data == a.map) begin
        in_data = b.map;
        cur_exp = b.exp_map;
      end
      if (cap_cnt == c0 + 2) in_valid = 1'b0;
      if (cap_cnt == c0 + 2 && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("lockout_timeout", 64'(cap_cnt - c0), 64'(2));

    // Reset mid-stream after beat 1.
    in_valid = 1'b1;
    in_data  = vecs[4].map;
    cur_exp  = vecs[4].exp_map;
    out_ready = 1'b1;
    c0 = cap_cnt;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (cap_cnt != c0) in_valid = 1'b0;
      if (cap_cnt != c0 && exp_q.size() == 2) done = 1'b1;
    end
    if (!done) check("midrst_timeout", 64'(exp_q.size()), 64'(2));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_outputs", 64'({in_ready, out_data, out_index, out_last}), 64'({1'b1, 35'h0}));
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    run_map(vecs[0]);

    // Single-element map on the N = 1 instance.
    s_in_data   = 32'hFFFF_0001;
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    step();
    s_in_valid = 1'b0;
    s_in_data  = 32'h0;
    check("one_valid", 64'({s_out_valid, s_in_ready}), 64'b10);
    check("one_index_last", 64'({s_out_index, s_out_last}), 64'b01);
    check("one_data", 64'(s_out_data), 64'(model_word(32'hFFFF_0001)));
    step();
    check("one_stall", 64'({s_out_valid, s_out_index, s_out_last, s_out_data}),
          64'({3'b101, model_word(32'hFFFF_0001)}));
    s_out_ready = 1'b1;
    step();
    check("one_done", 64'({s_out_valid, s_in_ready, s_out_last}), 64'b010);

    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
